// File: rtl/wb_pkg.sv
// Shared types and width helpers for the Wishbone round-robin arbiter.
package wb_pkg;

   typedef enum logic [0:0] {
      WB_ARB_IDLE  = 1'b0,
      WB_ARB_GRANT = 1'b1
   } wb_arb_state_e;

   // Byte-select width for a given data bus width.
   function automatic int wb_sel_width(input int data_width);
      return data_width / 8;
   endfunction

   // Width of a master index (at least one bit).
   function automatic int wb_idx_width(input int num_masters);
      return (num_masters > 1) ? $clog2(num_masters) : 1;
   endfunction

   // Width of a counter that must hold 0..max_val inclusive.
   function automatic int wb_cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module wb_rr_arbiter
   import wb_pkg::*;
#(
   parameter int NumReq = 2
) (
   input  logic [NumReq-1:0]               req_i,
   input  logic [wb_idx_width(NumReq)-1:0] last_i,
   output logic [wb_idx_width(NumReq)-1:0] gnt_o,
   output logic                            vld_o
);

   localparam int IdxW = wb_idx_width(NumReq);

   // Scan from last_i+1 through last_i itself; the first hit wins.
   always_comb begin
      logic [IdxW-1:0] k;
      gnt_o = last_i;
      vld_o = 1'b0;
      k     = '0;
      for (int i = 1; i <= NumReq; i++) begin
         k = IdxW'((int'(last_i) + i) % NumReq);
         if (!vld_o && req_i[k]) begin
            vld_o = 1'b1;
            gnt_o = k;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone B4 slave among
// NumMasters masters. Grant is held for a whole bus cycle; the outstanding
// counter bounds the pipeline depth.
// Optional watchdog: define WB_ARBITER_TIMEOUT_EN to terminate hung cycles.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DataWidth      = 32,
   parameter int AddrWidth      = 30,
   parameter int NumMasters     = 2,
   parameter int MaxOutstanding = 4,
   parameter int TimeoutCycles  = 255
) (
   input  logic                                           clk_i,
   input  logic                                           reset_i,
   input  logic [NumMasters*DataWidth-1:0]                m_data_i,
   input  logic [NumMasters*AddrWidth-1:0]                m_addr_i,
   input  logic [NumMasters*wb_sel_width(DataWidth)-1:0]  m_sel_i,
   input  logic [NumMasters-1:0]                          m_cyc_i,
   input  logic [NumMasters-1:0]                          m_stb_i,
   input  logic [NumMasters-1:0]                          m_we_i,
   output logic [DataWidth-1:0]                           m_data_o,
   output logic [NumMasters-1:0]                          m_ack_o,
   output logic [NumMasters-1:0]                          m_err_o,
   output logic [NumMasters-1:0]                          m_stall_o,
   output logic [DataWidth-1:0]                           s_data_o,
   output logic [AddrWidth-1:0]                           s_addr_o,
   output logic [wb_sel_width(DataWidth)-1:0]             s_sel_o,
   output logic                                           s_cyc_o,
   output logic                                           s_stb_o,
   output logic                                           s_we_o,
   input  logic [DataWidth-1:0]                           s_data_i,
   input  logic                                           s_ack_i,
   input  logic                                           s_err_i,
   input  logic                                           s_stall_i
);

   localparam int SelW = wb_sel_width(DataWidth);
   localparam int IdxW = wb_idx_width(NumMasters);
   localparam int CntW = wb_cnt_width(MaxOutstanding);

   wb_arb_state_e   state_q, state_d;
   logic [IdxW-1:0] gnt_q, gnt_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0] pick;
   logic            pick_vld;
   logic            full, accept, resp, timeout;

   logic [DataWidth-1:0] data_a [NumMasters];
   logic [AddrWidth-1:0] addr_a [NumMasters];
   logic [SelW-1:0]      sel_a  [NumMasters];

   for (genvar k = 0; k < NumMasters; k++) begin : g_split
      assign data_a[k] = m_data_i[k*DataWidth +: DataWidth];
      assign addr_a[k] = m_addr_i[k*AddrWidth +: AddrWidth];
      assign sel_a[k]  = m_sel_i[k*SelW +: SelW];
   end

   wb_rr_arbiter #(.NumReq(NumMasters)) u_rr (
      .req_i  (m_cyc_i),
      .last_i (ptr_q),
      .gnt_o  (pick),
      .vld_o  (pick_vld)
   );

   assign full     = (cnt_q == CntW'(MaxOutstanding));
   // Responses with nothing outstanding are stale and get dropped.
   assign resp     = (state_q == WB_ARB_GRANT) && (cnt_q != '0) && (s_ack_i || s_err_i);
   assign m_data_o = s_data_i;
   assign s_data_o = data_a[gnt_q];
   assign s_addr_o = addr_a[gnt_q];
   assign s_sel_o  = sel_a[gnt_q];
   assign s_we_o   = m_we_i[gnt_q];

`ifdef WB_ARBITER_TIMEOUT_EN
   localparam int WdW = $clog2(TimeoutCycles + 1);
   logic [WdW-1:0] wdog_q, wdog_d;

   assign timeout = (state_q == WB_ARB_GRANT) && (wdog_q == WdW'(TimeoutCycles));

   // Watchdog runs while transfers are outstanding and the slave is silent.
   always_comb begin
      wdog_d = '0;
      if (state_q == WB_ARB_GRANT && state_d == WB_ARB_GRANT && cnt_q != '0 && !resp)
         wdog_d = wdog_q + WdW'(1);
   end

   // Watchdog register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) wdog_q <= '0;
      else         wdog_q <= wdog_d;
   end
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TimeoutCycles);
   assign timeout        = 1'b0;
`endif

   // Next-state, counter and per-master response steering.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      m_ack_o   = '0;
      m_err_o   = '0;
      m_stall_o = '1;
      accept    = 1'b0;
      unique case (state_q)
         WB_ARB_IDLE: begin
            if (pick_vld) begin
               gnt_d   = pick;
               state_d = WB_ARB_GRANT;
            end
         end
         WB_ARB_GRANT: begin
            if (timeout) begin
               // Kill the cycle: error to the owner, bus dropped this cycle.
               m_err_o[gnt_q] = 1'b1;
               cnt_d          = '0;
               ptr_d          = gnt_q;
               state_d        = WB_ARB_IDLE;
            end else begin
               s_cyc_o          = m_cyc_i[gnt_q];
               s_stb_o          = m_stb_i[gnt_q] & ~full;
               m_stall_o[gnt_q] = s_stall_i | full;
               m_ack_o[gnt_q]   = s_ack_i & (cnt_q != '0);
               m_err_o[gnt_q]   = s_err_i & (cnt_q != '0);
               accept           = s_stb_o & ~s_stall_i;
               if (!m_cyc_i[gnt_q]) begin
                  // Owner released: abandon anything still in the slave.
                  cnt_d   = '0;
                  ptr_d   = gnt_q;
                  state_d = WB_ARB_IDLE;
               end else if (accept && !resp) begin
                  cnt_d = cnt_q + CntW'(1);
               end else if (resp && !accept) begin
                  cnt_d = cnt_q - CntW'(1);
               end
            end
         end
         default: state_d = WB_ARB_IDLE;
      endcase
   end

   // State, grant, pointer and outstanding counter registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= WB_ARB_IDLE;
         gnt_q   <= '0;
         ptr_q   <= IdxW'(NumMasters - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle vector table plus hand sequences
// for handover timing, fairness and the watchdog / hung-slave behaviour.
module tb_wb_arbiter;

   localparam int DW = 32, AW = 30, NM = 2, MO = 4, TO = 8;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic [NM*DW-1:0]  m_data_i;
   logic [NM*AW-1:0]  m_addr_i;
   logic [NM*4-1:0]   m_sel_i;
   logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
   logic [DW-1:0]     m_data_o;
   logic [NM-1:0]     m_ack_o, m_err_o, m_stall_o;
   logic [DW-1:0]     s_data_o;
   logic [AW-1:0]     s_addr_o;
   logic [3:0]        s_sel_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [DW-1:0]     s_data_i;
   logic              s_ack_i, s_err_i, s_stall_i;

   always #5 clk_i = ~clk_i;

   wb_arbiter #(.DataWidth(DW), .AddrWidth(AW), .NumMasters(NM),
                .MaxOutstanding(MO), .TimeoutCycles(TO)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .m_data_i(m_data_i), .m_addr_i(m_addr_i), .m_sel_i(m_sel_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
      .s_data_o(s_data_o), .s_addr_o(s_addr_o), .s_sel_o(s_sel_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i)
   );

   int n_cmp = 0, n_bad = 0;
   int ack_cnt[2];
   bit auto_ack = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Sample at the settled point, cross the clock, then let the slave model
   // acknowledge whatever was accepted in the previous cycle.
   task automatic adv();
      logic acc;
      acc = s_cyc_o & s_stb_o & ~s_stall_i;
      for (int k = 0; k < 2; k++) ack_cnt[k] += int'(m_ack_o[k]);
      @(posedge clk_i);
      #1;
      if (auto_ack) s_ack_i = acc;
   endtask

   task automatic do_reset();
      reset_i = 1'b1; m_cyc_i = '0; m_stb_i = '0; s_ack_i = 0; s_err_i = 0; s_stall_i = 0;
      #2; adv();
      reset_i = 1'b0;
      #2; adv();
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] cyc, stb;
      logic       ack, err, stall;
      logic       e_cyc, e_stb;
      logic [1:0] e_stall, e_ack, e_err;
      logic [AW-1:0] e_addr;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic rst, logic [1:0] cyc, logic [1:0] stb, logic ack,
                               logic err, logic stall, logic e_cyc, logic e_stb,
                               logic [1:0] e_stall, logic [1:0] e_ack, logic [1:0] e_err,
                               logic [AW-1:0] e_addr);
      vec_t v;
      v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.stall = stall;
      v.e_cyc = e_cyc; v.e_stb = e_stb; v.e_stall = e_stall; v.e_ack = e_ack;
      v.e_err = e_err; v.e_addr = e_addr;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int g, waits;
      logic got;
      m_addr_i = {30'h20, 30'h10};
      m_data_i = {32'hB1B1_1111, 32'hA0A0_0000};
      m_sel_i  = {4'hC, 4'h3};
      m_we_i   = 2'b10;
      m_cyc_i  = '0; m_stb_i = '0;
      s_data_i = '0; s_ack_i = 0; s_err_i = 0; s_stall_i = 0;
      reset_i  = 1'b1;
      ack_cnt[0] = 0; ack_cnt[1] = 0;

      //          rst cyc    stb    ack err stl  cyc stb stall  ack    err    addr
      tv.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 30'h0));  // reset
      tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 30'h0));
      tv.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 30'h0));  // req cycle 0
      tv.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 30'h10)); // m0 wins
      tv.push_back(mk(0, 2'b11, 2'b11, 1, 0, 0,  1, 1, 2'b10, 2'b01, 2'b00, 30'h10)); // ack+accept
      tv.push_back(mk(0, 2'b11, 2'b10, 1, 0, 0,  1, 0, 2'b10, 2'b01, 2'b00, 30'h10));
      tv.push_back(mk(0, 2'b10, 2'b10, 0, 0, 0,  0, 0, 2'b10, 2'b00, 2'b00, 30'h0));  // m0 release
      tv.push_back(mk(0, 2'b10, 2'b10, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 30'h0));  // idle gap
      tv.push_back(mk(0, 2'b10, 2'b10, 0, 0, 0,  1, 1, 2'b01, 2'b00, 2'b00, 30'h20)); // m1 owns
      tv.push_back(mk(0, 2'b10, 2'b00, 0, 1, 0,  1, 0, 2'b01, 2'b00, 2'b10, 30'h20)); // err fwd
      tv.push_back(mk(0, 2'b10, 2'b00, 1, 0, 0,  1, 0, 2'b01, 2'b00, 2'b00, 30'h20)); // stray ack
      tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b01, 2'b00, 2'b00, 30'h0));
      tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 30'h0));
      tv.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 30'h0));
      tv.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 30'h10)); // cnt->1
      tv.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 30'h10)); // ->2
      tv.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 30'h10)); // ->3
      tv.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 30'h10)); // ->4
      tv.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0,  1, 0, 2'b11, 2'b00, 2'b00, 30'h10)); // full
      tv.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0,  1, 0, 2'b11, 2'b01, 2'b00, 30'h10)); // ->3
      tv.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 30'h10)); // ->4
      tv.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0,  1, 0, 2'b11, 2'b00, 2'b00, 30'h10)); // full
      tv.push_back(mk(0, 2'b01, 2'b01, 1, 0, 1,  1, 0, 2'b11, 2'b01, 2'b00, 30'h10)); // ->3
      tv.push_back(mk(0, 2'b01, 2'b01, 0, 0, 1,  1, 1, 2'b11, 2'b00, 2'b00, 30'h10)); // stalled
      tv.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 30'h10)); // ->4
      tv.push_back(mk(1, 2'b01, 2'b01, 1, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 30'h0));  // async rst
      tv.push_back(mk(0, 2'b00, 2'b00, 1, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 30'h0));  // late ack

      @(posedge clk_i); #1;
      foreach (tv[i]) begin
         reset_i = tv[i].rst; m_cyc_i = tv[i].cyc; m_stb_i = tv[i].stb;
         s_ack_i = tv[i].ack; s_err_i = tv[i].err; s_stall_i = tv[i].stall;
         s_data_i = 32'hD000_0000 | i;
         #2;
         chk($sformatf("v%0d s_cyc", i),   s_cyc_o,   tv[i].e_cyc);
         chk($sformatf("v%0d s_stb", i),   s_stb_o,   tv[i].e_stb);
         chk($sformatf("v%0d m_stall", i), m_stall_o, tv[i].e_stall);
         chk($sformatf("v%0d m_ack", i),   m_ack_o,   tv[i].e_ack);
         chk($sformatf("v%0d m_err", i),   m_err_o,   tv[i].e_err);
         chk($sformatf("v%0d m_data", i),  m_data_o,  32'hD000_0000 | i);
         if (tv[i].e_cyc) begin
            chk($sformatf("v%0d s_addr", i), s_addr_o, tv[i].e_addr);
            chk($sformatf("v%0d s_we", i),   s_we_o,   (tv[i].e_addr == 30'h20));
            chk($sformatf("v%0d s_data", i), s_data_o,
                (tv[i].e_addr == 30'h20) ? 32'hB1B1_1111 : 32'hA0A0_0000);
            chk($sformatf("v%0d s_sel", i),  s_sel_o,
                (tv[i].e_addr == 30'h20) ? 4'hC : 4'h3);
         end
         adv();
      end

      // Contention and handover timing: both request in cycle 0.
      do_reset();
      m_cyc_i = 2'b11; m_stb_i = 2'b00;
      #2; chk("cont c0 s_cyc", s_cyc_o, 0); adv();
      #2; chk("cont c1 s_cyc", s_cyc_o, 1); chk("cont c1 addr", s_addr_o, 30'h10); adv();
      for (int c = 2; c < 5; c++) begin #2; adv(); end
      m_cyc_i[0] = 1'b0;
      #2; chk("cont c5 s_cyc", s_cyc_o, 0); adv();
      #2; chk("cont c6 s_cyc", s_cyc_o, 0); chk("cont c6 stall", m_stall_o, 2'b11); adv();
      #2; chk("cont c7 s_cyc", s_cyc_o, 1); chk("cont c7 addr", s_addr_o, 30'h20); adv();
      m_cyc_i = 2'b00;
      #2; adv(); #2; adv();

      // Fairness: both request continuously, 2 transfers per bus cycle.
      auto_ack = 1'b1;
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      for (int r = 0; r < 4; r++) begin
         got = 1'b0; waits = 0;
         for (int k = 0; k < 10 && !got; k++) begin
            #2;
            if (s_cyc_o) got = 1'b1;
            else begin adv(); waits++; end
         end
         chk($sformatf("fair r%0d granted", r), got, 1);
         g = (s_addr_o == 30'h20) ? 1 : 0;
         chk($sformatf("fair r%0d owner", r), g, r % 2);
         if (r > 0) chk($sformatf("fair r%0d gap", r), waits, 1);
         ack_cnt[0] = 0; ack_cnt[1] = 0;
         adv();
         #2; adv();
         m_stb_i[g] = 1'b0;
         #2; adv();
         m_cyc_i[g] = 1'b0;
         #2; adv();
         chk($sformatf("fair r%0d acks owner", r), ack_cnt[g], 2);
         chk($sformatf("fair r%0d acks other", r), ack_cnt[1-g], 0);
         m_cyc_i[g] = 1'b1; m_stb_i[g] = 1'b1;
      end
      auto_ack = 1'b0; s_ack_i = 1'b0;
      m_cyc_i = 2'b00; m_stb_i = 2'b00;
      #2; adv(); #2; adv();

      // Hung slave: one accepted strobe, never acknowledged.
      do_reset();
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      #2; adv();
      #2; chk("hang accept stb", s_stb_o, 1); adv();
      m_stb_i = 2'b00;
`ifdef WB_ARBITER_TIMEOUT_EN
      for (int c = 1; c <= 8; c++) begin
         #2; chk($sformatf("to A+%0d no err", c), m_err_o, 2'b00); adv();
      end
      #2;
      chk("to A+9 err", m_err_o, 2'b01);
      chk("to A+9 s_cyc", s_cyc_o, 0);
      adv();
      #2;
      chk("to A+10 s_cyc", s_cyc_o, 0);
      chk("to A+10 stall", m_stall_o, 2'b11);
      adv();
`else
      for (int c = 1; c <= 12; c++) begin
         #2;
         chk($sformatf("hang A+%0d no err", c), m_err_o, 2'b00);
         chk($sformatf("hang A+%0d s_cyc", c), s_cyc_o, 1);
         adv();
      end
`endif
      m_cyc_i = 2'b00;
      #2; adv(); #2; adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin arbiter sharing one pipelined Wishbone B4 slave port among `NumMasters` bus masters. Sits between CPU, DMA and debug masters and a single slave or interconnect segment. Grants are per bus cycle (`cyc` held) and tracked outstanding transfers bound the pipeline depth. Optional watchdog terminates hung cycles with an error.

## Interface
Parameters:
- `DataWidth`, default 32: data bus width.
- `AddrWidth`, default 30: word address width.
- `NumMasters`, default 2: number of requesters, 2..8.
- `MaxOutstanding`, default 4: accepted-but-unacknowledged transfers allowed, 1..15.
- `TimeoutCycles`, default 255: watchdog limit, in cycles without ack/err.

Ports. Master-side buses are packed, with master k in slice k.
- `clk_i`  in  1  single clock; all logic is on its rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `m_data_i`  in  NumMasters*DataWidth  master write data.
- `m_addr_i`  in  NumMasters*AddrWidth  master address.
- `m_sel_i`  in  NumMasters*DataWidth/8  master byte selects.
- `m_cyc_i`, `m_stb_i`, `m_we_i`  in  NumMasters  master control.
- `m_data_o`  out  DataWidth  read data, broadcast to all masters.
- `m_ack_o`, `m_err_o`, `m_stall_o`  out  NumMasters  per-master responses.
- `s_data_o`  out  DataWidth  slave-side write data.
- `s_addr_o`  out  AddrWidth  slave-side address.
- `s_sel_o`  out  DataWidth/8  slave-side byte selects.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  slave-side control.
- `s_data_i`  in  DataWidth  slave read data.
- `s_ack_i`, `s_err_i`, `s_stall_i`  in  1  slave responses.

## Operation
- States: IDLE, GRANT.
- IDLE:
  - `s_cyc_o`=0, `s_stb_o`=0; all `m_stall_o`=1.
  - If any `m_cyc_i` is set, the round-robin picker registers the winner. Search starts at (last granted + 1) mod NumMasters. Next state is GRANT.
- GRANT, for granted master g:
  - `s_cyc_o` = `m_cyc_i[g]`; `s_stb_o` = `m_stb_i[g]` & ~full.
  - addr, data, sel and we are muxed from g.
  - `m_stall_o[g]` = `s_stall_i` | full. All other masters' stall = 1.
  - `m_ack_o[g]` = `s_ack_i` and `m_err_o[g]` = `s_err_i`. Other masters' ack/err = 0.
- Outstanding counter:
  - +1 on accepted strobe (`s_stb_o` & ~`s_stall_i`); −1 on `s_ack_i`|`s_err_i`. Both in the same cycle: unchanged.
  - full = (count == MaxOutstanding).
- Release: `m_cyc_i[g]` falls → `s_cyc_o` falls in the same cycle. Counter clears to 0, the last-granted pointer is set to g, and the state returns to IDLE. Responses still pending in the slave are abandoned.
- Acks or errs arriving while the counter is 0 are dropped and not forwarded.
- Non-granted masters may hold `cyc`/`stb` indefinitely; they see stall=1 and no responses.

## Timing
- Reset values: state IDLE, pointer = NumMasters−1 (so master 0 wins the first arbitration), counter 0. `s_cyc_o`/`s_stb_o` = 0, all `m_ack_o`/`m_err_o` = 0, all `m_stall_o` = 1.
- Grant latency: `m_cyc_i` is raised in cycle 0, and `s_cyc_o`/`s_stb_o` are valid in cycle 1.
- Forward and response paths are combinational, adding zero cycles.
- Handover: the old master drops `cyc` in cycle N, state is IDLE in N+1, and the next master's `s_cyc_o` rises in N+2. There is one mandatory idle cycle between owners.
- Simultaneous requests in IDLE: the lowest index at or after pointer+1 wins, wrapping modulo NumMasters.
- `reset_i` mid-cycle: the outputs above apply immediately (asynchronous), and the in-flight transfer is discarded.

## Configuration
- `WB_ARBITER_TIMEOUT_EN` defined:
  - A watchdog counter counts cycles in GRANT with count>0 and no ack/err. It reloads on every ack/err.
  - On reaching TimeoutCycles: `m_err_o[g]`=1 for one cycle, `s_cyc_o` is forced 0 for that cycle, the counter clears and the state returns to IDLE.
  - The master must then drop `cyc` and re-request.
- Undefined: no watchdog; a hung slave holds the grant indefinitely.

## Structure
- Package `wb_pkg`:
  - state enum (`WB_ARB_IDLE`, `WB_ARB_GRANT`);
  - `wb_sel_width(DataWidth)` helper;
  - `$clog2`-based width constants for the grant index and the outstanding counter.
- Sub-module `wb_rr_arbiter`: combinational round-robin pick. Inputs are a request vector and the last-granted index; outputs are the winner index and a valid flag. The FSM, counters and muxing live in `wb_arbiter`.

## Test plan
- Single master: master 0 does 4 back-to-back pipelined reads at 0x10..0x13, slave acks one cycle after accept → 4 acks to master 0, data returned in order, `m_stall_o[1]` stays 1.
- Contention: both masters raise `cyc` in the same cycle after reset → master 0 granted in cycle 1. Master 0 drops `cyc` in cycle 5 → master 1's `s_cyc_o` rises in cycle 7.
- Fairness: both masters request continuously with 2-transfer cycles → grants alternate 0,1,0,1, and no master is granted twice in a row while the other requests.
- Backpressure: MaxOutstanding=4, slave stalls acks → after 4 accepts `m_stall_o[g]`=1 and `s_stb_o`=0. One ack → one further accept.
- Reset mid-cycle: assert `reset_i` with 2 transfers outstanding → `s_cyc_o`=0 and all stalls 1 immediately. Late slave acks are not forwarded.
- Timeout (with macro): TimeoutCycles=8, slave never acks → `m_err_o[g]` pulses 9 cycles after the accepted strobe, and the state is IDLE next cycle.
